// File: rtl/ysyx_exu_csr_file.sv
// Machine-mode CSR file for the EXU: trap/mret sequencing, masked writes, illegal-access detect.
// Define YSYX_CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters.
module ysyx_exu_csr_file #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VAL   = '0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] MVENDORID   = 32'h7973_7978,
    parameter logic [XLEN-1:0] MARCHID     = 32'h015f_de77
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [11:0]     addr_i,
    input  logic            wen_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            illegal_o,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            retire_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mstatus_mie_o
);
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

    logic            r_mie, r_mpie;
    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [XLEN-1:0] w_mstatus, w_rdata;
    logic [XLEN-1:0] w_cyc_lo, w_cyc_hi, w_ins_lo, w_ins_hi;
    logic            w_hit, w_ro, w_illegal, w_wr, w_trap, w_mret;

    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mpie;
        w_mstatus[3]     = r_mie;
    end

    always_comb begin
        w_rdata = '0;
        w_hit   = 1'b1;
        case (addr_i)
            ADDR_MSTATUS:   w_rdata = w_mstatus;
            ADDR_MTVEC:     w_rdata = r_mtvec;
            ADDR_MSCRATCH:  w_rdata = r_mscratch;
            ADDR_MEPC:      w_rdata = r_mepc;
            ADDR_MCAUSE:    w_rdata = r_mcause;
            ADDR_MTVAL:     w_rdata = r_mtval;
            ADDR_MCYCLE:    w_rdata = w_cyc_lo;
            ADDR_MCYCLEH:   w_rdata = w_cyc_hi;
            ADDR_MINSTRET:  w_rdata = w_ins_lo;
            ADDR_MINSTRETH: w_rdata = w_ins_hi;
            ADDR_MVENDORID: w_rdata = MVENDORID;
            ADDR_MARCHID:   w_rdata = MARCHID;
            default:        w_hit   = 1'b0;
        endcase
    end

    assign w_ro      = (addr_i == ADDR_MVENDORID) || (addr_i == ADDR_MARCHID);
    assign w_illegal = ~w_hit | (wen_i & w_ro);
    assign w_trap    = valid_i & trap_i;
    assign w_mret    = valid_i & mret_i & ~trap_i;
    assign w_wr      = valid_i & wen_i & ~trap_i & ~w_illegal;

    assign rdata_o       = w_rdata;
    assign illegal_o     = w_illegal;
    assign mtvec_o       = r_mtvec;
    assign mepc_o        = r_mepc;
    assign mstatus_mie_o = r_mie;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
            r_mepc     <= {RESET_VAL[XLEN-1:2], 2'b00};
            r_mcause   <= RESET_VAL;
            r_mtval    <= RESET_VAL;
            r_mscratch <= RESET_VAL;
        end else if (w_trap) begin
            // Trap wins over any same-cycle write or mret.
            r_mepc   <= {trap_pc_i[XLEN-1:2], 2'b00};
            r_mcause <= trap_cause_i;
            r_mtval  <= trap_tval_i;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else begin
            if (w_mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_wr && addr_i == ADDR_MSTATUS) begin
                r_mie  <= wdata_i[3];
                r_mpie <= wdata_i[7];
            end
            if (w_wr) begin
                case (addr_i)
                    ADDR_MTVEC:    r_mtvec    <= {wdata_i[XLEN-1:2], 2'b00};
                    ADDR_MEPC:     r_mepc     <= {wdata_i[XLEN-1:2], 2'b00};
                    ADDR_MSCRATCH: r_mscratch <= wdata_i;
                    ADDR_MCAUSE:   r_mcause   <= wdata_i;
                    ADDR_MTVAL:    r_mtval    <= wdata_i;
                    default: ;
                endcase
            end
        end
    end

`ifdef YSYX_CSR_COUNTERS_EN
    localparam logic [2*XLEN-1:0] CNT_ONE = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic [2*XLEN-1:0] r_mcycle, r_minstret;

    // A write to either half suppresses that counter's increment for the cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_wr && addr_i == ADDR_MCYCLE) begin
                r_mcycle <= {r_mcycle[2*XLEN-1:XLEN], wdata_i};
            end else if (w_wr && addr_i == ADDR_MCYCLEH) begin
                r_mcycle <= {wdata_i, r_mcycle[XLEN-1:0]};
            end else begin
                r_mcycle <= r_mcycle + CNT_ONE;
            end
            if (w_wr && addr_i == ADDR_MINSTRET) begin
                r_minstret <= {r_minstret[2*XLEN-1:XLEN], wdata_i};
            end else if (w_wr && addr_i == ADDR_MINSTRETH) begin
                r_minstret <= {wdata_i, r_minstret[XLEN-1:0]};
            end else if (valid_i && retire_i) begin
                r_minstret <= r_minstret + CNT_ONE;
            end
        end
    end

    assign w_cyc_lo = r_mcycle[XLEN-1:0];
    assign w_cyc_hi = r_mcycle[2*XLEN-1:XLEN];
    assign w_ins_lo = r_minstret[XLEN-1:0];
    assign w_ins_hi = r_minstret[2*XLEN-1:XLEN];
`else
    logic w_unused_retire;

    assign w_unused_retire = retire_i;
    assign w_cyc_lo        = '0;
    assign w_cyc_hi        = '0;
    assign w_ins_lo        = '0;
    assign w_ins_hi        = '0;
`endif

endmodule
